alu_arbiter: RTL

Shares one combinational ALU (8-bit operands, 3-bit opcode, 9-bit result plus carry-out) between `N_REQ` requesters in the neural-accelerator datapath. Each requester submits an operation through a valid/ready handshake. A round-robin scheduler grants one request at a time, drives the registered operands into the ALU, captures the result, and returns it on a single tagged response channel. It also keeps a free-running count of completed operations.

---
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the shared-ALU arbiter.
// Operand, opcode and ready vectors are packed with requester i in slice i.
interface alu_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [3*N_REQ-1:0] req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [8:0]         rsp_y;
    logic               rsp_co;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_co
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_co
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between N_REQ requesters.
// state | meaning
// IDLE  | search for a winner from ptr upward; handshake latches operands
// EXEC  | ALU settles on registered operands; result and carry captured
// RESP  | tagged response held until rsp_ready
module alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [8:0]    alu_y,
    input  logic          alu_co,
    output logic          busy,
    output logic [15:0]   ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] ptr_nx;
    logic [ID_W-1:0] id_reg;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            take;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic [2:0]      sel_op;
    logic [8:0]      y_reg;
    logic            co_reg;
    logic [15:0]     ops_cnt;

    // Rotating priority search; sum never exceeds 2*N_REQ-2, one subtraction wraps it
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        sel_a         = '0;
        sel_b         = '0;
        sel_op        = '0;
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt == ID_W'(i)) begin
                sel_a  = bus.req_a[8*i +: 8];
                sel_b  = bus.req_b[8*i +: 8];
                sel_op = bus.req_op[3*i +: 3];
            end
            bus.req_ready[i] = (state == IDLE) && found && (gnt == ID_W'(i));
        end
    end

    assign take   = (state == IDLE) && found;
    assign ptr_nx = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= '0;
            id_reg  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            y_reg   <= '0;
            co_reg  <= 1'b0;
            ops_cnt <= '0;
        end else begin
            if (take) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_op <= sel_op;
                id_reg <= gnt;
                ptr    <= ptr_nx;
            end
            if (state == EXEC) begin
                y_reg  <= alu_y;
                co_reg <= alu_co;
            end
            if ((state == RESP) && bus.rsp_ready) begin
                ops_cnt <= ops_cnt + 16'd1;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_y     = y_reg;
    assign bus.rsp_co    = co_reg;
    assign busy          = (state != IDLE);
    assign ops_done      = ops_cnt;
endmodule
